flag_unit: RTL and testbench

//  Holds the MCU's C and Z status flags. Captures the ALU's c/z outputs and feeds C back
//  to the ALU carry-in (cIn), which closes the ALU flag loop.

---
 rtl/flag_unit.sv | 111 +++++++++++
 tb/tb_flag_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - MCU C/Z/I status flags, interrupt-entry shadows, interrupt synchroniser and branch evaluation
module flag_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       flg_ld,
  input  logic       flg_c_set,
  input  logic       flg_c_clr,
  input  logic       shad_save,
  input  logic       shad_restore,
  input  logic       i_set,
  input  logic       i_clr,
  input  logic       intr_raw,
  input  logic       intr_ack,
  input  logic [1:0] cond,
  output logic       c_out,
  output logic       z_out,
  output logic       i_out,
  output logic       intr_pend,
  output logic       br_take
);

  logic                   c_q, z_q, sc_q, sz_q, i_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   pend_q;
  logic                   intr_rise;

  // A restore wins outright; a save leaves C/Z to the ALU/SEC/CLC path.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else if (shad_restore) begin
      c_q <= sc_q;
      z_q <= sz_q;
    end else if (flg_ld) begin
      c_q <= alu_c;
      z_q <= alu_z;
    end else if (flg_c_clr) begin
      c_q <= 1'b0;
    end else if (flg_c_set) begin
      c_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= 1'b0;
      sz_q <= 1'b0;
    end else if (shad_save) begin
      sc_q <= c_q;
      sz_q <= z_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= 1'b0;
    end else if (shad_restore) begin
      i_q <= 1'b1;
    end else if (shad_save || i_clr) begin
      i_q <= 1'b0;
    end else if (i_set) begin
      i_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], intr_raw};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign intr_rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  // A new edge beats a simultaneous ack so the fresh request is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else if (intr_rise) begin
      pend_q <= 1'b1;
    end else if (intr_ack) begin
      pend_q <= 1'b0;
    end
  end

  always_comb begin
    br_take = 1'b0;
    case (cond)
      2'd0:    br_take = ~c_q;
      2'd1:    br_take = c_q;
      2'd2:    br_take = z_q;
      2'd3:    br_take = ~z_q;
      default: br_take = 1'b0;
    endcase
  end

  assign c_out     = c_q;
  assign z_out     = z_q;
  assign i_out     = i_q;
  assign intr_pend = pend_q & i_q;

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - randomized and directed checks of flag_unit against a behavioural model
module tb_flag_unit;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst, alu_c, alu_z, flg_ld, flg_c_set, flg_c_clr;
  logic       shad_save, shad_restore, i_set, i_clr, intr_raw, intr_ack;
  logic [1:0] cond;
  logic       c_out, z_out, i_out, intr_pend, br_take;

  int tests = 0;
  int failed = 0;
  bit chk_en = 1'b0;

  flag_unit #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .alu_c(alu_c), .alu_z(alu_z), .flg_ld(flg_ld),
    .flg_c_set(flg_c_set), .flg_c_clr(flg_c_clr), .shad_save(shad_save),
    .shad_restore(shad_restore), .i_set(i_set), .i_clr(i_clr),
    .intr_raw(intr_raw), .intr_ack(intr_ack), .cond(cond),
    .c_out(c_out), .z_out(z_out), .i_out(i_out), .intr_pend(intr_pend),
    .br_take(br_take)
  );

  always #5 clk = ~clk;

  // Behavioural model: flags by rule, interrupt request as raw delayed by SYNC edges.
  bit m_c = 0, m_z = 0, m_sc = 0, m_sz = 0, m_i = 0, m_pend = 0;
  bit hist[$];

  initial for (int k = 0; k < SYNC + 2; k++) hist.push_back(1'b0);

  always @(posedge clk) begin
    bit nc, nz, delayed, delayed_prev;
    if (rst) begin
      {m_c, m_z, m_sc, m_sz, m_i, m_pend} = '0;
      for (int k = 0; k < SYNC + 2; k++) hist[k] = 1'b0;
    end else begin
      nc = m_c;
      nz = m_z;
      if (shad_restore)   begin nc = m_sc;  nz = m_sz; end
      else if (flg_ld)    begin nc = alu_c; nz = alu_z; end
      else if (flg_c_clr) nc = 1'b0;
      else if (flg_c_set) nc = 1'b1;
      if (shad_save) begin m_sc = m_c; m_sz = m_z; end
      m_c = nc;
      m_z = nz;
      if (shad_restore)            m_i = 1'b1;
      else if (shad_save || i_clr) m_i = 1'b0;
      else if (i_set)              m_i = 1'b1;
      hist.push_front(intr_raw);
      void'(hist.pop_back());
      delayed      = hist[SYNC];
      delayed_prev = hist[SYNC+1];
      if (delayed && !delayed_prev) m_pend = 1'b1;
      else if (intr_ack)            m_pend = 1'b0;
    end
  end

  function automatic bit m_br(input logic [1:0] cd);
    case (cd)
      2'd0: return !m_c;
      2'd1: return m_c;
      2'd2: return m_z;
      default: return !m_z;
    endcase
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_c", c_out, m_c);
      check("model_z", z_out, m_z);
      check("model_i", i_out, m_i);
      check("model_pend", intr_pend, m_pend & m_i);
      check("model_br", br_take, m_br(cond));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {rst, alu_c, alu_z, flg_ld, flg_c_set, flg_c_clr} = '0;
    {shad_save, shad_restore, i_set, i_clr, intr_ack} = '0;
  endtask

  initial begin
    idle();
    intr_raw = 1'b0;
    cond = 2'd0;
    // 1: reset dominates all-high inputs
    {rst, alu_c, alu_z, flg_ld, flg_c_set, flg_c_clr} = '1;
    {shad_save, shad_restore, i_set, i_clr, intr_ack, intr_raw} = '1;
    step();
    idle();
    intr_raw = 1'b0;
    chk_en = 1'b1;
    check("rst_c", c_out, 1'b0);
    check("rst_z", z_out, 1'b0);
    check("rst_i", i_out, 1'b0);
    check("rst_pend", intr_pend, 1'b0);

    // 2: load, then SEC+CLC together clears C
    alu_c = 1'b1; alu_z = 1'b0; flg_ld = 1'b1;
    step(); idle();
    check("ld_c", c_out, 1'b1);
    check("ld_z", z_out, 1'b0);
    flg_c_set = 1'b1; flg_c_clr = 1'b1;
    step(); idle();
    check("setclr_c", c_out, 1'b0);
    check("setclr_z", z_out, 1'b0);

    // 3: save, overwrite, restore
    alu_c = 1'b1; alu_z = 1'b1; flg_ld = 1'b1; i_set = 1'b1;
    step(); idle();
    shad_save = 1'b1;
    step(); idle();
    check("save_i", i_out, 1'b0);
    check("save_c", c_out, 1'b1);
    flg_ld = 1'b1;
    step(); idle();
    check("ld0_c", c_out, 1'b0);
    check("ld0_z", z_out, 1'b0);
    shad_restore = 1'b1;
    step(); idle();
    check("rest_c", c_out, 1'b1);
    check("rest_z", z_out, 1'b1);
    check("rest_i", i_out, 1'b1);

    // 4: held level gives one request with SYNC+1 edge latency
    intr_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k <= SYNC) check("lat_early", intr_pend, 1'b0);
      if (k == SYNC + 1) check("lat_hit", intr_pend, 1'b1);
    end
    intr_ack = 1'b1;
    step(); idle();
    check("ack_clear", intr_pend, 1'b0);
    for (int k = 0; k < 5; k++) step();
    check("level_once", intr_pend, 1'b0);
    intr_raw = 1'b0;
    for (int k = 0; k < SYNC + 2; k++) step();

    // 5: request captured while masked, shown once enabled
    i_clr = 1'b1;
    step(); idle();
    intr_raw = 1'b1;
    step();
    intr_raw = 1'b0;
    for (int k = 0; k < SYNC + 3; k++) step();
    check("masked", intr_pend, 1'b0);
    i_set = 1'b1;
    step(); idle();
    check("unmasked", intr_pend, 1'b1);
    intr_ack = 1'b1;
    step(); idle();

    // 6: branch condition sweeps
    alu_c = 1'b0; alu_z = 1'b1; flg_ld = 1'b1;
    step(); idle();
    for (int k = 0; k < 4; k++) begin
      cond = 2'(k);
      #1;
      check("br_c0z1", br_take, (k % 2) == 0);
    end
    alu_c = 1'b1; alu_z = 1'b0; flg_ld = 1'b1;
    step(); idle();
    for (int k = 0; k < 4; k++) begin
      cond = 2'(k);
      #1;
      check("br_c1z0", br_take, (k % 2) == 1);
    end

    // random phase against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      rst          = ($urandom_range(0, 63) == 0);
      alu_c        = 1'($urandom);
      alu_z        = 1'($urandom);
      flg_ld       = ($urandom_range(0, 3) == 0);
      flg_c_set    = ($urandom_range(0, 3) == 0);
      flg_c_clr    = ($urandom_range(0, 3) == 0);
      shad_save    = ($urandom_range(0, 7) == 0);
      shad_restore = ($urandom_range(0, 7) == 0);
      i_set        = ($urandom_range(0, 3) == 0);
      i_clr        = ($urandom_range(0, 5) == 0);
      intr_ack     = ($urandom_range(0, 7) == 0);
      cond         = 2'($urandom);
      if ($urandom_range(0, 5) == 0) intr_raw = ~intr_raw;
    end
    step();
    idle();
    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
